// File: rtl/mem_result_packer.sv
// mem_result_packer: packs a stream of result bytes little-endian into 32-bit
// words and writes them through the scratch memory write port. When the job
// ends it pulses o_wr_file so the memory dumps its image, then pulses o_done.
// Optional feature macro: PACKER_FLUSH_EN. When it is defined, i_in_last exists
// and ends the job early. Upper bytes of a partial word are filled with PAD_BYTE.
module mem_result_packer #(
  parameter int         MEM_DEPTH = 128,
  parameter logic [7:0] PAD_BYTE  = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_base_adr,
  input  logic [7:0]  i_word_count,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [7:0]  i_in_data,
`ifdef PACKER_FLUSH_EN
  input  logic        i_in_last,
`endif
  output logic        o_wr_en,
  output logic [7:0]  o_wr_adr,
  output logic [31:0] o_wr_data,
  output logic        o_wr_file,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [7:0] ADR_MASK = 8'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_PACK, S_WRITE, S_DUMP, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_base;
  logic [7:0]  r_count;
  logic [7:0]  r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_acc;        // lower three bytes of the word under assembly
  logic [7:0]  r_wr_adr;
  logic [31:0] r_wr_data;

  logic        w_xfer;
  logic        w_last_byte;
  logic        w_word_end;
  logic        w_flush_end;
  logic [31:0] w_packed;
  logic [7:0]  w_word_idx_inc;
  logic [7:0]  w_adr_sum;

  assign w_xfer         = (r_state == S_PACK) && i_in_valid;
  assign w_word_end     = w_xfer && ((r_byte_idx == 2'd3) || w_last_byte);
  assign w_word_idx_inc = r_word_idx + 8'd1;
  assign w_adr_sum      = r_base + r_word_idx;

`ifdef PACKER_FLUSH_EN
  logic r_last;
  assign w_last_byte = i_in_last;
  assign w_flush_end = r_last;

  // Remember that the word being written was closed by in_last.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b0;
    end else if (r_state == S_IDLE && i_start) begin
      r_last <= 1'b0;
    end else if (w_xfer && i_in_last) begin
      r_last <= 1'b1;
    end
  end
`else
  assign w_last_byte = 1'b0;
  assign w_flush_end = 1'b0;
`endif

  // Assemble the outgoing word: earlier bytes, the incoming byte, then padding.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pack
      if (gi < 3) begin : g_low
        assign w_packed[8*gi +: 8] = (2'(gi) < r_byte_idx)  ? r_acc[8*gi +: 8] :
                                     (2'(gi) == r_byte_idx) ? i_in_data : PAD_BYTE;
      end else begin : g_top
        assign w_packed[8*gi +: 8] = (r_byte_idx == 2'd3) ? i_in_data : PAD_BYTE;
      end
    end
  endgenerate

  // Job bookkeeping, byte assembly and the held write-port registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_base     <= 8'd0;
      r_count    <= 8'd0;
      r_word_idx <= 8'd0;
      r_byte_idx <= 2'd0;
      r_acc      <= 24'd0;
      r_wr_adr   <= 8'd0;
      r_wr_data  <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && i_start) begin
        r_base     <= i_base_adr;
        r_count    <= i_word_count;
        r_word_idx <= 8'd0;
        r_byte_idx <= 2'd0;
      end
      if (w_xfer) begin
        case (r_byte_idx)
          2'd0:    r_acc[7:0]   <= i_in_data;
          2'd1:    r_acc[15:8]  <= i_in_data;
          2'd2:    r_acc[23:16] <= i_in_data;
          default: ;
        endcase
        r_byte_idx <= w_word_end ? 2'd0 : r_byte_idx + 2'd1;
        if (w_word_end) begin
          r_wr_data <= w_packed;
          r_wr_adr  <= w_adr_sum & ADR_MASK;
        end
      end
      if (r_state == S_WRITE) begin
        r_word_idx <= w_word_idx_inc;
      end
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_wr_en      = 1'b0;
    o_wr_file    = 1'b0;
    o_done       = 1'b0;
    o_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_state_next = (i_word_count == 8'd0) ? S_DUMP : S_PACK;
        end
      end
      S_PACK: begin
        o_in_ready = 1'b1;
        if (w_word_end) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        o_wr_en = 1'b1;
        if (w_flush_end || (w_word_idx_inc == r_count)) begin
          w_state_next = S_DUMP;
        end else begin
          w_state_next = S_PACK;
        end
      end
      S_DUMP: begin
        o_wr_file    = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_wr_adr  = r_wr_adr;
  assign o_wr_data = r_wr_data;

endmodule
